// File: rtl/mmm_pkg.sv
// Shared widths, row-normaliser state encoding and protocol error causes
// for the 90-bit limb multiplier datapath.
package mmm_pkg;
  localparam int LIMBW = 90;
  localparam int PRODW = 2 * LIMBW + 1;
  localparam int CARW  = LIMBW + 1;
  localparam int MAXL  = 8;
  localparam int IDXW  = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACC      = 2'd1,
    FLUSH_LO = 2'd2,
    FLUSH_HI = 2'd3
  } state_t;

  // Bit positions in the per-cycle error-cause vector.
  localparam int ERR_FLUSH_BEAT   = 0;
  localparam int ERR_NO_FIRST     = 1;
  localparam int ERR_FIRST_IN_ACC = 2;
  localparam int ERR_OVERLEN      = 3;
  localparam int ERR_NUM          = 4;
endpackage

// File: rtl/mul90_limb_add.sv
// Combinational product + carry (+ optional previous-row addend) sum, split into
// a 90-bit limb and a 91-bit carry. Addend input exists only with ROW_ADDEND_EN.
module mul90_limb_add
  import mmm_pkg::*;
(
  input  logic [PRODW-1:0] prod,
  input  logic [CARW-1:0]  carry,
`ifdef ROW_ADDEND_EN
  input  logic [LIMBW-1:0] addend,
`endif
  output logic [LIMBW-1:0] limb,
  output logic [CARW-1:0]  carry_out
);
  logic [PRODW-1:0] sum;

  // Operand bounds keep the sum below 2^181, so no carry out of PRODW exists.
  always_comb begin
    sum = prod + PRODW'(carry);
`ifdef ROW_ADDEND_EN
    sum = sum + PRODW'(addend);
`endif
  end

  assign limb      = sum[LIMBW-1:0];
  assign carry_out = sum[PRODW-1:LIMBW];
endmodule

// File: rtl/mul90_row_norm.sv
// Row normaliser: folds each product's high part into the next beat and emits
// 90-bit limbs plus two flush limbs. Optional addend port under ROW_ADDEND_EN.
module mul90_row_norm
  import mmm_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_clr,
  input  logic             i_vld,
  input  logic             i_first,
  input  logic             i_last,
  input  logic [PRODW-1:0] i_prod,
`ifdef ROW_ADDEND_EN
  input  logic [LIMBW-1:0] i_addend,
`endif
  output logic             o_rdy,
  output logic             o_vld,
  output logic [LIMBW-1:0] o_limb,
  output logic [IDXW-1:0]  o_idx,
  output logic             o_last,
  output logic             o_err
);
  state_t             state, state_nxt;
  logic [CARW-1:0]    hi, hi_nxt, carry_in, sum_hi;
  logic [IDXW-1:0]    cnt, cnt_nxt, beat_idx, idx_nxt;
  logic [LIMBW-1:0]   sum_limb, limb_nxt;
  logic               vld_nxt, last_nxt;
  logic               take_first, take_mid, accept;
  logic [ERR_NUM-1:0] err_cause;

  // A first beat in ACC abandons the open row and restarts from this beat.
  assign take_first = i_vld & i_first & ((state == IDLE) | (state == ACC));
  assign take_mid   = i_vld & ~i_first & (state == ACC);
  assign accept     = take_first | take_mid;
  assign carry_in   = i_first ? '0 : hi;
  assign beat_idx   = i_first ? '0 : cnt;
  assign o_rdy      = (state == IDLE) | ((state == ACC) & ~(i_vld & i_last));

  mul90_limb_add u_add (
    .prod      (i_prod),
    .carry     (carry_in),
`ifdef ROW_ADDEND_EN
    .addend    (i_addend),
`endif
    .limb      (sum_limb),
    .carry_out (sum_hi)
  );

  always_comb begin
    state_nxt = state;
    hi_nxt    = hi;
    cnt_nxt   = cnt;
    vld_nxt   = 1'b0;
    last_nxt  = 1'b0;
    limb_nxt  = o_limb;
    idx_nxt   = o_idx;
    err_cause = '0;
    case (state)
      IDLE, ACC: begin
        if (accept) begin
          vld_nxt   = 1'b1;
          limb_nxt  = sum_limb;
          idx_nxt   = beat_idx;
          hi_nxt    = sum_hi;
          cnt_nxt   = beat_idx + IDXW'(1);
          state_nxt = ACC;
          if (i_last) begin
            state_nxt = FLUSH_LO;
          end else if (beat_idx == IDXW'(MAXL - 1)) begin
            state_nxt              = FLUSH_LO;
            err_cause[ERR_OVERLEN] = 1'b1;
          end
        end
        err_cause[ERR_NO_FIRST]     = (state == IDLE) & i_vld & ~i_first;
        err_cause[ERR_FIRST_IN_ACC] = (state == ACC) & i_vld & i_first;
      end
      FLUSH_LO: begin
        vld_nxt   = 1'b1;
        limb_nxt  = hi[LIMBW-1:0];
        idx_nxt   = cnt;
        cnt_nxt   = cnt + IDXW'(1);
        state_nxt = FLUSH_HI;
        err_cause[ERR_FLUSH_BEAT] = i_vld;
      end
      FLUSH_HI: begin
        vld_nxt   = 1'b1;
        limb_nxt  = LIMBW'(hi[LIMBW]);
        idx_nxt   = cnt;
        last_nxt  = 1'b1;
        cnt_nxt   = '0;
        state_nxt = IDLE;
        err_cause[ERR_FLUSH_BEAT] = i_vld;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state  <= IDLE;
      hi     <= '0;
      cnt    <= '0;
      o_vld  <= 1'b0;
      o_limb <= '0;
      o_idx  <= '0;
      o_last <= 1'b0;
      o_err  <= 1'b0;
    end else if (i_clr) begin
      state  <= IDLE;
      hi     <= '0;
      cnt    <= '0;
      o_vld  <= 1'b0;
      o_last <= 1'b0;
      o_err  <= 1'b0;
    end else begin
      state  <= state_nxt;
      hi     <= hi_nxt;
      cnt    <= cnt_nxt;
      o_vld  <= vld_nxt;
      o_limb <= limb_nxt;
      o_idx  <= idx_nxt;
      o_last <= last_nxt;
      o_err  <= o_err | (|err_cause);
    end
  end
endmodule

// File: tb/tb_mul90_row_norm.sv
// Self-checking bench for mul90_row_norm: directed table, multi-cycle corner
// sequences and randomized rows against a wide-arithmetic reference model.
module tb_mul90_row_norm;
  import mmm_pkg::*;

  logic             i_clk = 1'b0;
  logic             i_rstn, i_clr, i_vld, i_first, i_last;
  logic [PRODW-1:0] i_prod;
  logic             o_rdy, o_vld, o_last, o_err;
  logic [LIMBW-1:0] o_limb;
  logic [IDXW-1:0]  o_idx;
`ifdef ROW_ADDEND_EN
  logic [LIMBW-1:0] i_addend = '0;
`endif

  always #5 i_clk = ~i_clk;

  mul90_row_norm dut (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .i_clr   (i_clr),
    .i_vld   (i_vld),
    .i_first (i_first),
    .i_last  (i_last),
    .i_prod  (i_prod),
`ifdef ROW_ADDEND_EN
    .i_addend(i_addend),
`endif
    .o_rdy   (o_rdy),
    .o_vld   (o_vld),
    .o_limb  (o_limb),
    .o_idx   (o_idx),
    .o_last  (o_last),
    .o_err   (o_err)
  );

  localparam logic [199:0] TWO90 = 200'(1) << 90;

  int checks = 0;
  int errors = 0;

  // Reference model: row/flush phase, carry as a plain integer, expected outputs.
  int               m_row = 0;
  int               m_fl  = 0;
  int               m_n   = 0;
  logic [199:0]     m_hi  = '0;
  logic             m_err = 1'b0;
  logic             m_vld = 1'b0;
  logic             m_last = 1'b0;
  logic [LIMBW-1:0] m_limb = '0;
  logic [IDXW-1:0]  m_idx = '0;

  typedef struct {
    logic             vld, first, last, clr;
    logic [PRODW-1:0] prod;
    logic             rdy, ovld;
    logic [LIMBW-1:0] limb;
    logic [IDXW-1:0]  idx;
    logic             olast, err;
  } vec_t;

  vec_t tbl[14];

  function automatic vec_t mk(logic v, logic f, logic l, logic c, logic [PRODW-1:0] p,
                              logic r, logic ov, logic [LIMBW-1:0] lb, int ix,
                              logic ol, logic e);
    vec_t t;
    t.vld = v; t.first = f; t.last = l; t.clr = c; t.prod = p;
    t.rdy = r; t.ovld = ov; t.limb = lb; t.idx = IDXW'(ix); t.olast = ol; t.err = e;
    return t;
  endfunction

  function automatic logic [LIMBW-1:0] rnd90();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[LIMBW-1:0];
  endfunction

  task automatic chk(input string name, input logic [199:0] act, input logic [199:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: drive inputs, check o_rdy, advance model, check registered outputs.
  task automatic cyc(input logic vld, input logic first, input logic last,
                     input logic [PRODW-1:0] prod, input logic clr, output logic rdy_seen);
    logic [199:0] s;
    int           bi;
    logic         exp_rdy;
    i_vld = vld; i_first = first; i_last = last; i_prod = prod; i_clr = clr;
    #1;
    exp_rdy  = (m_row == 0 && m_fl == 0) || (m_row == 1 && !(vld && last));
    rdy_seen = o_rdy;
    chk("rdy", o_rdy, exp_rdy);
    m_vld = 1'b0; m_last = 1'b0;
    if (clr) begin
      m_row = 0; m_fl = 0; m_hi = '0; m_n = 0; m_err = 1'b0;
    end else if (m_fl == 1) begin
      m_vld = 1'b1; m_limb = LIMBW'(m_hi % TWO90); m_idx = IDXW'(m_n);
      m_n++; m_fl = 2;
      if (vld) m_err = 1'b1;
    end else if (m_fl == 2) begin
      m_vld = 1'b1; m_limb = LIMBW'(m_hi / TWO90); m_idx = IDXW'(m_n); m_last = 1'b1;
      m_n = 0; m_fl = 0;
      if (vld) m_err = 1'b1;
    end else if (vld) begin
      if (m_row == 0 && !first) begin
        m_err = 1'b1;
      end else begin
        if (m_row == 1 && first) m_err = 1'b1;
        s = 200'(prod) + (first ? 200'(0) : m_hi);
`ifdef ROW_ADDEND_EN
        s = s + 200'(i_addend);
`endif
        bi = first ? 0 : m_n;
        m_vld = 1'b1; m_limb = LIMBW'(s % TWO90); m_idx = IDXW'(bi);
        m_hi = s / TWO90; m_n = bi + 1; m_row = 1;
        if (last) begin
          m_row = 0; m_fl = 1;
        end else if (m_n == MAXL) begin
          m_err = 1'b1; m_row = 0; m_fl = 1;
        end
      end
    end
    @(posedge i_clk);
    #1;
    chk("vld", o_vld, m_vld);
    chk("limb", o_limb, m_limb);
    chk("last", o_last, m_last);
    chk("err", o_err, m_err);
    if (m_vld) chk("idx", o_idx, m_idx);
  endtask

  initial begin
    logic             r;
    logic [PRODW-1:0] p, m1, a, b;
    logic             v, f, l, c;

    i_rstn = 1'b0; i_clr = 1'b0; i_vld = 1'b0; i_first = 1'b0; i_last = 1'b0; i_prod = '0;
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_vld", o_vld, 0);
    chk("rst_limb", o_limb, 0);
    chk("rst_idx", o_idx, 0);
    chk("rst_last", o_last, 0);
    chk("rst_err", o_err, 0);
    i_rstn = 1'b1;
    @(posedge i_clk);
    #1;

    // Single-beat row, max-carry row, flush-time beat, stray beat, clears.
    tbl[0]  = mk(1, 1, 1, 0, (PRODW'(1) << 90) + PRODW'(5), 1, 1, 5, 0, 0, 0);
    tbl[1]  = mk(0, 0, 0, 0, '0, 0, 1, 1, 1, 0, 0);
    tbl[2]  = mk(0, 0, 0, 0, '0, 0, 1, 0, 2, 1, 0);
    tbl[3]  = mk(0, 0, 0, 0, '0, 1, 0, 0, 0, 0, 0);
    tbl[4]  = mk(1, 1, 1, 0, PRODW'(1) << 180, 1, 1, 0, 0, 0, 0);
    tbl[5]  = mk(0, 0, 0, 0, '0, 0, 1, 0, 1, 0, 0);
    tbl[6]  = mk(0, 0, 0, 0, '0, 0, 1, 1, 2, 1, 0);
    tbl[7]  = mk(1, 1, 1, 0, PRODW'(7), 1, 1, 7, 0, 0, 0);
    tbl[8]  = mk(1, 0, 0, 0, PRODW'(3), 0, 1, 0, 1, 0, 1);
    tbl[9]  = mk(0, 0, 0, 0, '0, 0, 1, 0, 2, 1, 1);
    tbl[10] = mk(0, 0, 0, 0, '0, 1, 0, 0, 0, 0, 1);
    tbl[11] = mk(0, 0, 0, 1, '0, 1, 0, 0, 0, 0, 0);
    tbl[12] = mk(1, 0, 0, 0, PRODW'(9), 1, 0, 0, 0, 0, 1);
    tbl[13] = mk(0, 0, 0, 1, '0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 14; i++) begin
      cyc(tbl[i].vld, tbl[i].first, tbl[i].last, tbl[i].prod, tbl[i].clr, r);
      chk($sformatf("tbl%0d_rdy", i), r, tbl[i].rdy);
      chk($sformatf("tbl%0d_vld", i), o_vld, tbl[i].ovld);
      chk($sformatf("tbl%0d_last", i), o_last, tbl[i].olast);
      chk($sformatf("tbl%0d_err", i), o_err, tbl[i].err);
      if (tbl[i].ovld) begin
        chk($sformatf("tbl%0d_limb", i), o_limb, tbl[i].limb);
        chk($sformatf("tbl%0d_idx", i), o_idx, tbl[i].idx);
      end
    end

    // Carry chain of three (2^90-1)^2+1 beats.
    m1 = (PRODW'(1) << 90) - PRODW'(1);
    p  = m1 * m1 + PRODW'(1);
    cyc(1, 1, 0, p, 0, r); chk("chain0", o_limb, 2);
    cyc(1, 0, 0, p, 0, r); chk("chain1", o_limb, 0);
    cyc(1, 0, 1, p, 0, r); chk("chain2", o_limb, 1);
    cyc(0, 0, 0, '0, 0, r); chk("chain_flo", o_limb, m1); chk("chain_flo_idx", o_idx, 3);
    cyc(0, 0, 0, '0, 0, r); chk("chain_fhi", o_limb, 0); chk("chain_fhi_last", o_last, 1);

    // Overlength row: eight beats with no i_last.
    cyc(1, 1, 0, PRODW'(11), 0, r);
    for (int i = 1; i < MAXL; i++) cyc(1, 0, 0, PRODW'(11 + i), 0, r);
    chk("overlen_err", o_err, 1);
    chk("overlen_rdy", o_rdy, 0);
    cyc(0, 0, 0, '0, 0, r); chk("overlen_flo_idx", o_idx, 8);
    cyc(0, 0, 0, '0, 0, r); chk("overlen_fhi_idx", o_idx, 9); chk("overlen_fhi_last", o_last, 1);
    cyc(0, 0, 0, '0, 1, r);

    // Asynchronous reset between beats 2 and 3 of a row.
    cyc(1, 1, 0, m1 * m1, 0, r);
    cyc(1, 0, 0, m1 * m1, 0, r);
    i_vld = 1'b0; i_first = 1'b0; i_last = 1'b0;
    i_rstn = 1'b0;
    #1;
    chk("arst_vld", o_vld, 0);
    chk("arst_limb", o_limb, 0);
    chk("arst_idx", o_idx, 0);
    chk("arst_last", o_last, 0);
    chk("arst_err", o_err, 0);
    m_row = 0; m_fl = 0; m_n = 0; m_hi = '0; m_err = 1'b0; m_limb = '0; m_idx = '0;
    @(posedge i_clk);
    #1;
    i_rstn = 1'b1;
    cyc(1, 1, 1, PRODW'(5), 0, r);
    chk("arst_next_idx", o_idx, 0);
    chk("arst_next_limb", o_limb, 5);
    cyc(0, 0, 0, '0, 0, r); chk("arst_next_hi", o_limb, 0);
    cyc(0, 0, 0, '0, 0, r);

    // Randomized rows against the model.
    for (int i = 0; i < 600; i++) begin
      v = ($urandom_range(0, 3) != 0);
      f = (m_row == 0 && m_fl == 0) ? ($urandom_range(0, 4) != 0) : ($urandom_range(0, 9) == 0);
      l = ($urandom_range(0, 3) == 0);
      c = ($urandom_range(0, 59) == 0);
      a = PRODW'(rnd90());
      b = PRODW'(rnd90());
`ifdef ROW_ADDEND_EN
      i_addend = rnd90();
`endif
      cyc(v, f, l, a * b, c, r);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
